// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: chip-select style memory bus (CEN/WEN/OEN active-low) plus ready strobe.
interface data_mem_responder_if;
   logic        CEN;
   logic        WEN;
   logic        OEN;
   logic [6:0]  A;
   logic [31:0] D;
   logic [31:0] Q;
   logic        ready;
   modport master (output CEN, WEN, OEN, A, D, input Q, ready);
   modport slave  (input CEN, WEN, OEN, A, D, output Q, ready);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: 128x32 memory answering each request after WAIT_STATES wait cycles.
// Define DMEM_CLEAR_EN to also zero the whole array on reset.
module data_mem_responder #(
   parameter int WAIT_STATES = 2
) (
   input logic clk,
   input logic reset,
   data_mem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam logic [2:0] CNT_LOAD = 3'(WAIT_STATES - 1);
   state_t      state, state_n;
   logic [2:0]  cnt;
   logic [6:0]  a_r, a_sel;
   logic [31:0] d_r, d_sel, q_r;
   logic        wen_r, wen_sel, commit;
   logic [31:0] mem [128];
   // With zero wait states the commit happens on the capture edge, so use the live inputs then.
   assign a_sel   = (state == IDLE) ? bus.A   : a_r;
   assign d_sel   = (state == IDLE) ? bus.D   : d_r;
   assign wen_sel = (state == IDLE) ? bus.WEN : wen_r;
   always_comb begin
      state_n = IDLE;
      if (state == IDLE) state_n = bus.CEN ? IDLE : ((WAIT_STATES == 0) ? DONE : WAIT);
      else if (state == WAIT) state_n = (cnt == 3'd0) ? DONE : WAIT;
   end
   assign commit = !reset && (state_n == DONE);
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         q_r <= '0;
      end else begin
         if (state == IDLE && !bus.CEN) begin
            a_r   <= bus.A;
            d_r   <= bus.D;
            wen_r <= bus.WEN;
            cnt   <= CNT_LOAD;
         end else if (state == WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end
         if (commit && wen_sel) q_r <= mem[a_sel];
      end
   end
   always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
      if (reset) begin
         for (int i = 0; i < 128; i++) mem[i] <= '0;
      end else
`endif
      if (commit && !wen_sel) mem[a_sel] <= d_sel;
   end
   assign bus.ready = (state == DONE);
   assign bus.Q     = bus.OEN ? '0 : q_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (WAIT_STATES=2 and 0 instances).
module tb_data_mem_responder;
   localparam int WS = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   logic [31:0] mem_m [128];
   logic [31:0] q_m = '0;
   logic [31:0] sb [$];
   data_mem_responder_if bus ();
   data_mem_responder_if bus0 ();
   data_mem_responder #(.WAIT_STATES(WS)) dut (.clk(clk), .reset(reset), .bus(bus));
   data_mem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      q_m = '0;
`ifdef DMEM_CLEAR_EN
      for (int i = 0; i < 128; i++) mem_m[i] = '0;
`endif
   endtask
   task automatic quiet_check(input string tag);
      logic seen = 1'b0;
      repeat (WS + 3) begin
         @(negedge clk);
         seen = seen | bus.ready;
      end
      check(tag, {31'd0, seen}, 32'd0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.CEN = 1'b0; bus.WEN = 1'b0; bus.A = 7'h33; bus.D = 32'hBAD0BAD0;
      @(negedge clk);
      reset = 1'b0;
      bus.CEN = 1'b1;
      model_reset();
      check("rst_ready", {31'd0, bus.ready}, 32'd0);
      check("rst_q", bus.Q, 32'd0);
      quiet_check("rst_no_capture");
   endtask
   task automatic access(input bit w, input logic [6:0] a, input logic [31:0] d, input bit disturb);
      int n;
      logic [31:0] e;
      @(negedge clk);
      bus.CEN = 1'b0; bus.WEN = !w; bus.A = a; bus.D = d;
      if (w) mem_m[a] = d;
      else q_m = mem_m[a];
      sb.push_back(q_m);
      @(posedge clk);
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.ready) break;
         if (disturb) begin
            bus.A = a + 7'd1; bus.D = '0; bus.WEN = 1'b0; bus.CEN = 1'b0;
         end else bus.CEN = 1'b1;
      end
      bus.CEN = 1'b1;
      check("latency", 32'(n), 32'(WS));
      e = sb.pop_front();
      check(w ? "q_after_wr" : "rd_data", bus.Q, e);
      @(negedge clk);
      check("ready_one_cycle", {31'd0, bus.ready}, 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1);
   end
   initial begin
      int prev, cnt_p;
      bus.CEN = 1'b1; bus.WEN = 1'b1; bus.OEN = 1'b0; bus.A = '0; bus.D = '0;
      bus0.CEN = 1'b1; bus0.WEN = 1'b1; bus0.OEN = 1'b0; bus0.A = '0; bus0.D = '0;
      for (int i = 0; i < 128; i++) mem_m[i] = '0;
      repeat (2) @(posedge clk);
      do_reset();
      access(1'b1, 7'h05, 32'hDEADBEEF, 1'b0);
      access(1'b0, 7'h05, 32'h0, 1'b0);
      access(1'b1, 7'h05, 32'h11111111, 1'b0);
      access(1'b0, 7'h05, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      bus.OEN = 1'b1;
      #1 check("oen_forces_zero", bus.Q, 32'd0);
      bus.OEN = 1'b0;
      #1 check("q_held_idle", bus.Q, 32'h11111111);
      access(1'b1, 7'h11, 32'h5A5A5A5A, 1'b0);
      access(1'b1, 7'h10, 32'hAAAA5555, 1'b1);
      access(1'b0, 7'h10, 32'h0, 1'b0);
      access(1'b0, 7'h11, 32'h0, 1'b0);
      access(1'b1, 7'h20, 32'h00000077, 1'b0);
      @(negedge clk);
      bus.CEN = 1'b0; bus.WEN = 1'b0; bus.A = 7'h20; bus.D = 32'h1;
      @(negedge clk);
      bus.CEN = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check("abort_ready", {31'd0, bus.ready}, 32'd0);
      check("abort_q", bus.Q, 32'd0);
      quiet_check("abort_no_pulse");
      access(1'b0, 7'h20, 32'h0, 1'b0);
      access(1'b1, 7'h40, 32'hCAFEF00D, 1'b0);
      do_reset();
      access(1'b0, 7'h40, 32'h0, 1'b0);
      access(1'b1, 7'h01, 32'h0BADCAFE, 1'b0);
      @(negedge clk);
      bus.CEN = 1'b0; bus.WEN = 1'b1; bus.A = 7'h01;
      prev = -1;
      cnt_p = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            cnt_p++;
            check("stream_q", bus.Q, mem_m[1]);
            if (prev >= 0) check("stream_gap", 32'(i - prev), 32'(WS + 2));
            prev = i;
         end
      end
      bus.CEN = 1'b1;
      check("stream_count", 32'(cnt_p), 32'((29 - WS) / (WS + 2) + 1));
      repeat (WS + 3) @(negedge clk);
      q_m = mem_m[1];
      @(negedge clk);
      bus0.CEN = 1'b0; bus0.WEN = 1'b0; bus0.A = 7'h7F; bus0.D = 32'h12345678;
      @(negedge clk);
      check("ws0_wr_ready", {31'd0, bus0.ready}, 32'd1);
      bus0.WEN = 1'b1;
      @(negedge clk);
      check("ws0_idle_gap", {31'd0, bus0.ready}, 32'd0);
      @(negedge clk);
      check("ws0_rd_ready", {31'd0, bus0.ready}, 32'd1);
      check("ws0_rd_q", bus0.Q, 32'h12345678);
      bus0.CEN = 1'b1;
      bus0.OEN = 1'b1;
      #1 check("ws0_oen_q", bus0.Q, 32'd0);
      bus0.OEN = 1'b0;
      @(negedge clk);
      check("ws0_ready_drop", {31'd0, bus0.ready}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
